conv_linebuf_scheduler: RTL and testbench

- Sequences the four-entry row line buffer that feeds the 3x3 convolution window for 640x640 frames.
- Accepts a raster pixel stream and generates write strobes, addresses and a rotating 2-bit write-buffer select (mod-4 row rotation).
- Issues matching reads of the two previous rows, so the downstream window-former receives a top/mid/bottom column triplet per accepted pixel once two rows are resident.

---
 rtl/conv_linebuf_scheduler.sv | 125 ++++++++++++
 tb/tb_conv_linebuf_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_linebuf_scheduler.sv
// Write/read sequencer for the four-row line buffer feeding a 3x3 convolution window.
// Rows rotate through the buffers mod 4; the two previous rows are read alongside each live pixel.
module conv_linebuf_scheduler #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 640,
    parameter int COL_W = 10,
    parameter int ROW_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_en,
    output logic [1:0]       wr_buf_sel,
    output logic [COL_W-1:0] wr_addr,
    output logic             rd_en,
    output logic [COL_W-1:0] rd_addr,
    output logic [1:0]       rd_sel_top,
    output logic [1:0]       rd_sel_mid,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [ROW_W-1:0] row_idx,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [COL_W-1:0] LAST_COL      = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW      = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] FILL_LAST_ROW = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_ONE       = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE       = ROW_W'(1);

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [1:0]       sel_q, sel_d;
    logic             win_valid_q, win_valid_d;
    logic             accept;
    logic             row_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            sel_q       <= '0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            sel_q       <= sel_d;
            win_valid_q <= win_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        sel_d       = sel_q;
        win_valid_d = win_valid_q;
        in_ready    = 1'b0;
        frame_done  = 1'b0;
        row_end     = (col_q == LAST_COL);

        case (state_q)
            IDLE:    if (start) state_d = FILL;
            FILL:    in_ready = 1'b1;
            RUN:     in_ready = !win_valid_q || win_ready;
            DRAIN:   if (!win_valid_q || win_ready) state_d = DONE;
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
                col_d      = '0;
                row_d      = '0;
                sel_d      = '0;
            end
            default: state_d = IDLE;
        endcase

        accept = in_valid && in_ready;

        // The last row holds its index so the counter never wraps inside a frame.
        if (accept) begin
            if (row_end) begin
                col_d = '0;
                sel_d = sel_q + 2'd1;
                if (row_q != LAST_ROW) row_d = row_q + ROW_ONE;
                if (state_q == FILL && row_q == FILL_LAST_ROW) state_d = RUN;
                if (state_q == RUN && row_q == LAST_ROW) state_d = DRAIN;
            end else begin
                col_d = col_q + COL_ONE;
            end
        end

        // A triplet appears one cycle after its read; it is held until taken.
        if (state_q == RUN && accept) begin
            win_valid_d = 1'b1;
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    assign wr_en      = accept;
    assign rd_en      = accept && (state_q == RUN);
    assign wr_addr    = accept ? col_q : '0;
    assign rd_addr    = rd_en ? col_q : '0;
    assign wr_buf_sel = sel_q;
    assign rd_sel_top = sel_q - 2'd2;
    assign rd_sel_mid = sel_q - 2'd1;
    assign win_valid  = win_valid_q;
    assign row_idx    = row_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_conv_linebuf_scheduler.sv
// Self-checking bench for conv_linebuf_scheduler on a 4x5 frame.
// A pixel-count model predicts every output each cycle; per-frame statistics pin it with literals.
module tb_conv_linebuf_scheduler;

    localparam int W  = 4;
    localparam int H  = 5;
    localparam int CW = 2;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          win_ready = 1'b0;
    logic          in_ready;
    logic          wr_en;
    logic [1:0]    wr_buf_sel;
    logic [CW-1:0] wr_addr;
    logic          rd_en;
    logic [CW-1:0] rd_addr;
    logic [1:0]    rd_sel_top;
    logic [1:0]    rd_sel_mid;
    logic          win_valid;
    logic [RW-1:0] row_idx;
    logic          busy;
    logic          frame_done;

    int checks = 0;
    int failures = 0;

    conv_linebuf_scheduler #(
        .IMG_W(W),
        .IMG_H(H),
        .COL_W(CW),
        .ROW_W(RW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .wr_en(wr_en),
        .wr_buf_sel(wr_buf_sel),
        .wr_addr(wr_addr),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_sel_top(rd_sel_top),
        .rd_sel_mid(rd_sel_mid),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .row_idx(row_idx),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Model: a frame is just a count of accepted pixels plus a pending-triplet flag.
    bit m_active = 0;
    bit m_drain = 0;
    bit m_done = 0;
    bit m_win = 0;
    int m_acc = 0;
    logic m_running, m_fill, m_rdy;

    assign m_running = m_active && !m_drain && !m_done;
    assign m_fill    = m_running && (m_acc < 2 * W);
    assign m_rdy     = m_running && (m_fill || !m_win || win_ready);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active <= 0;
            m_drain  <= 0;
            m_done   <= 0;
            m_win    <= 0;
            m_acc    <= 0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1;
                m_acc    <= 0;
            end
        end else if (m_done) begin
            m_active <= 0;
            m_done   <= 0;
        end else if (m_drain) begin
            if (!m_win || win_ready) begin
                m_done  <= 1;
                m_drain <= 0;
                m_win   <= 0;
            end
        end else begin
            if (m_rdy && in_valid && !m_fill) m_win <= 1;
            else if (win_ready) m_win <= 0;
            if (m_rdy && in_valid) begin
                m_acc <= m_acc + 1;
                if (m_acc + 1 == W * H) m_drain <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_in_ready", in_ready, 0);
            checkOutput("rst_wr_en", wr_en, 0);
            checkOutput("rst_rd_en", rd_en, 0);
            checkOutput("rst_win_valid", win_valid, 0);
            checkOutput("rst_frame_done", frame_done, 0);
            checkOutput("rst_row_idx", row_idx, 0);
            checkOutput("rst_wr_buf_sel", wr_buf_sel, 0);
        end else begin
            checkOutput("busy", busy, m_active);
            checkOutput("in_ready", in_ready, m_rdy);
            checkOutput("wr_en", wr_en, m_rdy && in_valid);
            checkOutput("rd_en", rd_en, m_rdy && in_valid && !m_fill);
            checkOutput("win_valid", win_valid, m_win);
            checkOutput("frame_done", frame_done, m_done);
            if (m_running) begin
                checkOutput("row_idx", row_idx, m_acc / W);
                checkOutput("wr_buf_sel", wr_buf_sel, (m_acc / W) % 4);
                checkOutput("rd_sel_top", rd_sel_top, ((m_acc / W) + 2) % 4);
                checkOutput("rd_sel_mid", rd_sel_mid, ((m_acc / W) + 3) % 4);
            end
            if (!m_active) checkOutput("idle_row_idx", row_idx, 0);
            if (m_rdy && in_valid) checkOutput("wr_addr", wr_addr, m_acc % W);
            if (m_rdy && in_valid && !m_fill) checkOutput("rd_addr", rd_addr, m_acc % W);
        end
    end

    // Per-frame statistics observed on the DUT pins.
    int cyc = 0;
    int acc_num, first_acc_cyc, last_acc_cyc, first_rd, first_top, first_mid;
    int row4_sel, row4_top, row4_mid, beats, done_cnt, done_cyc, busy_fall_cyc;
    int sel_seq[H];
    bit prev_busy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (in_valid && in_ready) begin
                if (acc_num % W == 0 && acc_num / W < H) sel_seq[acc_num / W] = wr_buf_sel;
                if (acc_num == 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                if (rd_en && first_rd == 0) begin
                    first_rd  = acc_num + 1;
                    first_top = rd_sel_top;
                    first_mid = rd_sel_mid;
                end
                if (acc_num == 4 * W) begin
                    row4_sel = wr_buf_sel;
                    row4_top = rd_sel_top;
                    row4_mid = rd_sel_mid;
                end
                acc_num++;
            end
            if (win_valid && win_ready) beats++;
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_busy && !busy) busy_fall_cyc = cyc;
        end
        prev_busy = busy;
    end

    task automatic clearStats();
        acc_num = 0; first_acc_cyc = -1; last_acc_cyc = -1; first_rd = 0;
        first_top = -1; first_mid = -1; row4_sel = -1; row4_top = -1; row4_mid = -1;
        beats = 0; done_cnt = 0; done_cyc = -1; busy_fall_cyc = -1;
        for (int i = 0; i < H; i++) sel_seq[i] = -1;
    endtask

    task automatic applyStimulus(input bit toggle_fill, input bit do_stall, input int reset_at,
                                 input int restart_at, input bit idle_valid);
        int  budget = 0;
        int  stall_left = 0;
        bit  stall_done = 0;
        bit  restart_done = 0;
        bit  aborted = 0;
        clearStats();
        win_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = toggle_fill ? 1'b0 : 1'b1;
        while (done_cnt == 0 && !aborted && budget < 200) begin
            if (reset_at >= 0 && m_acc == reset_at) begin
                reset = 1'b0;
                #1;
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_in_ready", in_ready, 0);
                checkOutput("abort_win_valid", win_valid, 0);
                checkOutput("abort_wr_buf_sel", wr_buf_sel, 0);
                checkOutput("abort_row_idx", row_idx, 0);
                in_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                reset = 1'b1;
                aborted = 1;
            end else begin
                if (toggle_fill && m_acc < 2 * W) in_valid = ~in_valid;
                else in_valid = 1'b1;
                if (do_stall && !stall_done && m_acc == 13) begin
                    stall_left = 3;
                    stall_done = 1;
                end
                if (stall_left > 0) begin
                    win_ready = 1'b0;
                    stall_left--;
                end else begin
                    win_ready = 1'b1;
                end
                if (restart_at >= 0 && !restart_done && m_acc == restart_at) begin
                    start = 1'b1;
                    restart_done = 1;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                budget++;
            end
        end
        start = 1'b0;
        if (!aborted) checkOutput("frame_timeout", done_cnt, 1);
        in_valid = idle_valid;
        win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic checkFullFrame(input string tag);
        int exp_seq[H] = '{0, 1, 2, 3, 0};
        checkOutput({tag, "_accepts"}, acc_num, 20);
        checkOutput({tag, "_accept_span"}, last_acc_cyc - first_acc_cyc, 19);
        checkOutput({tag, "_first_rd_accept"}, first_rd, 9);
        checkOutput({tag, "_first_rd_top"}, first_top, 0);
        checkOutput({tag, "_first_rd_mid"}, first_mid, 1);
        checkOutput({tag, "_row4_sel"}, row4_sel, 0);
        checkOutput({tag, "_row4_top"}, row4_top, 2);
        checkOutput({tag, "_row4_mid"}, row4_mid, 3);
        checkOutput({tag, "_beats"}, beats, 12);
        checkOutput({tag, "_done_count"}, done_cnt, 1);
        checkOutput({tag, "_done_latency"}, done_cyc - last_acc_cyc, 2);
        checkOutput({tag, "_busy_fall"}, busy_fall_cyc - done_cyc, 1);
        for (int r = 0; r < H; r++)
            checkOutput($sformatf("%s_sel_row%0d", tag, r), sel_seq[r], exp_seq[r]);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_in_ready", in_ready, 0);
        reset = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_ignores_valid", in_ready, 0);

        $display("[TB] frame A: continuous stream");
        applyStimulus(0, 0, -1, -1, 0);
        checkFullFrame("A");

        $display("[TB] frame B: toggled fill, stalled row 3");
        applyStimulus(1, 1, -1, -1, 0);
        checkOutput("B_accepts", acc_num, 20);
        checkOutput("B_accept_span", last_acc_cyc - first_acc_cyc, 29);
        checkOutput("B_beats", beats, 12);
        checkOutput("B_done_count", done_cnt, 1);

        $display("[TB] frame C: reset at row 3 col 2");
        applyStimulus(0, 0, 14, -1, 0);
        checkOutput("C_accepts", acc_num, 14);
        checkOutput("C_done_count", done_cnt, 0);

        $display("[TB] frame D: replay with start during RUN");
        applyStimulus(0, 0, -1, 10, 1);
        checkFullFrame("D");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("D_idle_in_ready", in_ready, 0);
        checkOutput("D_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
